// File: rtl/z80_pkg.sv
// Shared Z80 core types: condition codes, flag bits, sequencer states.
// Bus cycle-type codes match the z80fi monitor's encoding.
package z80_pkg;

  typedef enum logic [2:0] {
    CC_NZ = 3'd0,
    CC_Z  = 3'd1,
    CC_NC = 3'd2,
    CC_C  = 3'd3,
    CC_PO = 3'd4,
    CC_PE = 3'd5,
    CC_P  = 3'd6,
    CC_M  = 3'd7
  } cc_e;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_PV = 2;
  localparam int FLAG_C  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_RD_LO,
    ST_RD_HI,
    ST_FIN
  } seq_state_e;

  localparam logic [1:0] CYC_M1  = 2'd0;
  localparam logic [1:0] CYC_MRD = 2'd1;
  localparam logic [1:0] CYC_MWR = 2'd2;
  localparam logic [1:0] CYC_INT = 2'd3;

endpackage

// File: rtl/z80_cond_eval.sv
// Z80 condition-code evaluator (cc, F) -> taken.
// Shared by RET cc, JP cc, CALL cc and JR cc.
module z80_cond_eval
  import z80_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [7:0] flags,
  output logic       taken
);

  logic unused_flags;
  assign unused_flags = ^{flags[5:3], flags[1]};

  always_comb begin
    taken = 1'b0;
    unique case (cc_e'(cc))
      CC_NZ: taken = !flags[FLAG_Z];
      CC_Z:  taken =  flags[FLAG_Z];
      CC_NC: taken = !flags[FLAG_C];
      CC_C:  taken =  flags[FLAG_C];
      CC_PO: taken = !flags[FLAG_PV];
      CC_PE: taken =  flags[FLAG_PV];
      CC_P:  taken = !flags[FLAG_S];
      CC_M:  taken =  flags[FLAG_S];
    endcase
  end

endmodule

// File: rtl/z80_stack_pop_seq.sv
// Return-family sequencer: pops IP from (SP),(SP+1), SP += 2.
// Z80_RETN_IFF_EN: RETN/RETI copy IFF2 into IFF1 on a taken return.
module z80_stack_pop_seq
  import z80_pkg::*;
#(
  parameter int EXT_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_cond,
  input  logic [2:0]  cc,
  input  logic        is_retn,
  input  logic [7:0]  flags,
  input  logic [15:0] sp_in,
  input  logic [15:0] ip_in,
  input  logic        iff2,
  output logic        busy,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        done,
  output logic        taken,
  output logic [15:0] ip_out,
  output logic [15:0] sp_out,
  output logic        iff1_wr,
  output logic        iff1_val,
  output logic [2:0]  mcycles
);

  seq_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  cc_q, cc_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  lo_q, lo_d;
  logic        taken_q, taken_d;
  logic [15:0] ip_out_q, ip_out_d;
  logic [15:0] sp_out_q, sp_out_d;
  logic [2:0]  mcyc_q, mcyc_d;
  logic        cc_ok;

  z80_cond_eval u_cond (
    .cc    (cc_q),
    .flags (flags_q),
    .taken (cc_ok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cc_q     <= '0;
      flags_q  <= '0;
      sp_q     <= '0;
      ip_q     <= '0;
      lo_q     <= '0;
      taken_q  <= 1'b0;
      ip_out_q <= '0;
      sp_out_q <= '0;
      mcyc_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cc_q     <= cc_d;
      flags_q  <= flags_d;
      sp_q     <= sp_d;
      ip_q     <= ip_d;
      lo_q     <= lo_d;
      taken_q  <= taken_d;
      ip_out_q <= ip_out_d;
      sp_out_q <= sp_out_d;
      mcyc_q   <= mcyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cc_d     = cc_q;
    flags_d  = flags_q;
    sp_d     = sp_q;
    ip_d     = ip_q;
    lo_d     = lo_q;
    taken_d  = taken_q;
    ip_out_d = ip_out_q;
    sp_out_d = sp_out_q;
    mcyc_d   = mcyc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cc_d    = cc;
          flags_d = flags;
          sp_d    = sp_in;
          ip_d    = ip_in;
          cnt_d   = 8'(EXT_TICKS - 1);
          state_d = is_cond ? ST_EXT : ST_RD_LO;
        end
      end
      ST_EXT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (cc_ok) begin
          state_d = ST_RD_LO;
        end else begin
          state_d  = ST_FIN;
          taken_d  = 1'b0;
          ip_out_d = ip_q;
          sp_out_d = sp_q;
          mcyc_d   = 3'd0;
        end
      end
      ST_RD_LO: begin
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        if (mem_ack) begin
          state_d  = ST_FIN;
          taken_d  = 1'b1;
          ip_out_d = {mem_rdata, lo_q};
          sp_out_d = sp_q + 16'd2;
          mcyc_d   = 3'd2;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops them at once
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_FIN);
    mem_rd   = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);
    mem_addr = '0;
    if (state_q == ST_RD_LO) mem_addr = sp_q;
    if (state_q == ST_RD_HI) mem_addr = sp_q + 16'd1;
  end

  assign taken   = taken_q;
  assign ip_out  = ip_out_q;
  assign sp_out  = sp_out_q;
  assign mcycles = mcyc_q;

`ifdef Z80_RETN_IFF_EN
  logic retn_q;
  logic iff2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retn_q <= 1'b0;
      iff2_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      retn_q <= is_retn;
      iff2_q <= iff2;
    end
  end

  assign iff1_wr  = done && taken_q && retn_q;
  assign iff1_val = iff1_wr && iff2_q;
`else
  logic unused_retn;
  assign unused_retn = ^{is_retn, iff2};
  assign iff1_wr  = 1'b0;
  assign iff1_val = 1'b0;
`endif

  no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset_n) !(start && busy)
  );

endmodule

// File: tb/tb_z80_stack_pop_seq.sv
// Directed bench for z80_stack_pop_seq with a wait-state memory model.
// Cycle numbering counts the start cycle as cycle 1.
module tb_z80_stack_pop_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_cond = 1'b0;
  logic [2:0]  cc = '0;
  logic        is_retn = 1'b0;
  logic [7:0]  flags = '0;
  logic [15:0] sp_in = '0;
  logic [15:0] ip_in = '0;
  logic        iff2 = 1'b0;
  logic        busy, mem_rd, mem_ack, done, taken;
  logic        iff1_wr, iff1_val;
  logic [15:0] mem_addr, ip_out, sp_out;
  logic [7:0]  mem_rdata;
  logic [2:0]  mcycles;

  logic [7:0] mem [0:65535];
  int wait_n = 0;
  int wcnt = 0;

  int checks = 0;
  int errors = 0;

  int lat, rd_cycles, addr_bad, ack_cnt, ack2_cyc;
  int got_done, busy2, done_after;
  logic [15:0] a_lo, a_hi, r_ip, r_sp, hold_ip;
  logic [2:0]  r_mc;
  logic        r_taken, r_wr, r_val;
  logic        exp_wr;

  z80_stack_pop_seq #(.EXT_TICKS(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_cond   (is_cond),
    .cc        (cc),
    .is_retn   (is_retn),
    .flags     (flags),
    .sp_in     (sp_in),
    .ip_in     (ip_in),
    .iff2      (iff2),
    .busy      (busy),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (done),
    .taken     (taken),
    .ip_out    (ip_out),
    .sp_out    (sp_out),
    .iff1_wr   (iff1_wr),
    .iff1_val  (iff1_val),
    .mcycles   (mcycles)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_rd && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_rd || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic c_en, input logic [2:0] c_cc,
                       input logic retn, input logic [7:0] f,
                       input logic [15:0] sp, input logic [15:0] ip,
                       input logic i2);
    int acks_before;
    @(negedge clk);
    is_cond = c_en; cc = c_cc; is_retn = retn; flags = f;
    sp_in = sp; ip_in = ip; iff2 = i2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; rd_cycles = 0; addr_bad = 0; ack_cnt = 0;
    ack2_cyc = 0; got_done = 0; busy2 = 0;
    a_lo = 16'hxxxx; a_hi = 16'hxxxx;
    acks_before = 0;
    for (int cyc = 2; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 2) busy2 = int'(busy);
      if (mem_rd) begin
        rd_cycles++;
        if (mem_addr !== (acks_before == 0 ? sp : 16'(sp + 16'd1)))
          addr_bad++;
      end
      if (mem_ack) begin
        ack_cnt++;
        if (ack_cnt == 1) a_lo = mem_addr;
        if (ack_cnt == 2) begin a_hi = mem_addr; ack2_cyc = cyc; end
        acks_before++;
      end
      if (done) begin
        got_done = 1; lat = cyc;
        r_taken = taken; r_ip = ip_out; r_sp = sp_out; r_mc = mcycles;
        r_wr = iff1_wr; r_val = iff1_val;
        break;
      end
    end
    @(negedge clk);
    done_after = int'(done);
    hold_ip = ip_out;
  endtask

  initial begin
`ifdef Z80_RETN_IFF_EN
    exp_wr = 1'b1;
`else
    exp_wr = 1'b0;
`endif
    mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h4000] = 8'h78; mem[16'h4001] = 8'h56;
    mem[16'h5000] = 8'h11; mem[16'h5001] = 8'h22;
    mem[16'h3000] = 8'hEF; mem[16'h3001] = 8'hBE;
    mem[16'h6000] = 8'h99; mem[16'h6001] = 8'h88;
    mem[16'hFFFE] = 8'h55;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ip_out", 32'(ip_out), 32'd0);
    chk("rst_sp_out", 32'(sp_out), 32'd0);
    chk("rst_mcycles", 32'(mcycles), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    reset_n = 1'b1;

    // Plain RET, zero wait states
    wait_n = 0;
    do_op(1'b0, 3'd0, 1'b0, 8'h00, 16'h1000, 16'h0101, 1'b0);
    chk("ret_done", 32'(got_done), 32'd1);
    chk("ret_latency", 32'(lat), 32'd4);
    chk("ret_busy", 32'(busy2), 32'd1);
    chk("ret_ip", 32'(r_ip), 32'h1234);
    chk("ret_sp", 32'(r_sp), 32'h1002);
    chk("ret_mc", 32'(r_mc), 32'd2);
    chk("ret_taken", 32'(r_taken), 32'd1);
    chk("ret_addr", 32'(addr_bad), 32'd0);
    chk("ret_iffwr", 32'(r_wr), 32'd0);
    chk("ret_pulse", 32'(done_after), 32'd0);
    chk("ret_hold", 32'(hold_ip), 32'h1234);

    // RET Z not taken
    do_op(1'b1, 3'd1, 1'b0, 8'h00, 16'h2000, 16'h4321, 1'b0);
    chk("retz_done", 32'(got_done), 32'd1);
    chk("retz_rd", 32'(rd_cycles), 32'd0);
    chk("retz_taken", 32'(r_taken), 32'd0);
    chk("retz_ip", 32'(r_ip), 32'h4321);
    chk("retz_sp", 32'(r_sp), 32'h2000);
    chk("retz_mc", 32'(r_mc), 32'd0);

    // RET M taken across the top of memory
    do_op(1'b1, 3'd7, 1'b0, 8'h80, 16'hFFFF, 16'h0200, 1'b0);
    chk("retm_done", 32'(got_done), 32'd1);
    chk("retm_alo", 32'(a_lo), 32'hFFFF);
    chk("retm_ahi", 32'(a_hi), 32'h0000);
    chk("retm_ip", 32'(r_ip), 32'hABCD);
    chk("retm_sp", 32'(r_sp), 32'h0001);
    chk("retm_mc", 32'(r_mc), 32'd2);
    chk("retm_taken", 32'(r_taken), 32'd1);

    // RET with three wait cycles per read
    wait_n = 3;
    do_op(1'b0, 3'd0, 1'b0, 8'h00, 16'h4000, 16'h0300, 1'b0);
    chk("wait_done", 32'(got_done), 32'd1);
    chk("wait_rdcyc", 32'(rd_cycles), 32'd8);
    chk("wait_addr", 32'(addr_bad), 32'd0);
    chk("wait_fin", 32'(lat - ack2_cyc), 32'd1);
    chk("wait_ip", 32'(r_ip), 32'h5678);
    chk("wait_sp", 32'(r_sp), 32'h4002);

    // Reset while in RD_HI
    @(negedge clk);
    sp_in = 16'h5000; is_cond = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 20 && ack_cnt == 0; i++) begin
      @(negedge clk);
      if (mem_ack) ack_cnt++;
    end
    @(negedge clk);
    chk("mid_in_rdhi", 32'(mem_rd && mem_addr == 16'h5001), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    got_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    chk("mid_nodone", 32'(got_done), 32'd0);
    reset_n = 1'b1;
    wait_n = 0;
    do_op(1'b0, 3'd0, 1'b0, 8'h00, 16'h3000, 16'h0400, 1'b0);
    chk("post_done", 32'(got_done), 32'd1);
    chk("post_lat", 32'(lat), 32'd4);
    chk("post_ip", 32'(r_ip), 32'hBEEF);
    chk("post_sp", 32'(r_sp), 32'h3002);

    // RETN with IFF2 set
    do_op(1'b0, 3'd0, 1'b1, 8'h00, 16'h6000, 16'h0500, 1'b1);
    chk("retn_ip", 32'(r_ip), 32'h8899);
    chk("retn_wr", 32'(r_wr), 32'(exp_wr));
    chk("retn_val", 32'(r_val), 32'(exp_wr));

    // RET PE taken, SP wraps to 0000
    do_op(1'b1, 3'd5, 1'b0, 8'h04, 16'hFFFE, 16'h0600, 1'b0);
    chk("wrap_ip", 32'(r_ip), 32'hCD55);
    chk("wrap_sp", 32'(r_sp), 32'h0000);

    // RET NC not taken with carry set
    do_op(1'b1, 3'd2, 1'b0, 8'h01, 16'h1000, 16'h0700, 1'b0);
    chk("retnc_taken", 32'(r_taken), 32'd0);
    chk("retnc_ip", 32'(r_ip), 32'h0700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_stack_pop_seq.md
Name: z80_stack_pop_seq

Overview:
- Execution-side sequencer for the return family: RET (C9), RET cc (11ccc000), RETN (ED 45) and RETI (ED 4D).
- This is the inverse of the call push path:
  - reads return address low byte from SP and high byte from SP+1;
  - loads IP with the result;
  - advances SP by 2.
- Sits between the core's decode stage (which has completed M1) and the memory bus arbiter.
- Reports retirement info to the z80fi monitor.

Parameters:
- EXT_TICKS, 1, extra T-states inserted after M1 for RET cc before the condition is acted on.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: M1 finished, return-family opcode decoded
- is_cond  in  1  opcode is RET cc
- cc  in  3  condition field (NZ,Z,NC,C,PO,PE,P,M)
- is_retn  in  1  opcode is RETN or RETI
- flags  in  8  F register at start
- sp_in  in  16  SP at start
- ip_in  in  16  IP at start (already points past opcode)
- iff2  in  1  current IFF2
- busy  out  1  sequencer active
- mem_rd  out  1  memory read request, level, held until mem_ack
- mem_addr  out  16  read address
- mem_ack  in  1  one-cycle pulse; read data valid in this cycle
- mem_rdata  in  8  read data
- done  out  1  one-cycle pulse, results valid
- taken  out  1  return taken (valid with done)
- ip_out  out  16  next IP (valid with done)
- sp_out  out  16  next SP (valid with done)
- iff1_wr  out  1  write iff1_val to IFF1 (valid with done)
- iff1_val  out  1  value for IFF1
- mcycles  out  3  memory cycles performed, 0 or 2 (valid with done)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; internal address/data registers 0.
- States: IDLE, EXT, RD_LO, RD_HI, FIN.
- IDLE:
  - On start, latch all inputs.
  - is_cond=1 -> EXT, counter loaded with EXT_TICKS-1.
  - is_cond=0 -> RD_LO.
  - busy=1 from the cycle after start.
- EXT: counts down.
  - At 0, evaluate cc against latched flags: NZ Z=0, Z Z=1, NC C=0, C C=1, PO P/V=0, PE P/V=1, P S=0, M S=1.
  - Taken -> RD_LO; not taken -> FIN with taken=0, ip_out=ip_in, sp_out=sp_in, mcycles=0.
- RD_LO:
  - mem_rd=1, mem_addr=sp_lat.
  - On mem_ack, capture mem_rdata as low byte -> RD_HI.
  - Wait states are unlimited; mem_rd stays high.
- RD_HI:
  - mem_rd=1, mem_addr=sp_lat+1 (16-bit wrap).
  - On mem_ack, capture high byte -> FIN.
  - mem_rd drops the cycle after ack.
- FIN:
  - done=1 for exactly one cycle; taken=1; ip_out={hi,lo}; sp_out=sp_lat+2 (mod 2^16); mcycles=2.
  - Next state IDLE, busy=0.
- Latency: RET with zero wait states = 2 read handshakes + 1 cycle FIN. A start-to-done count of 4 cycles is only a figure for the ack-timing case tested below and is not a general minimum; FIN follows the RD_HI ack by one cycle.
- Wrap-around:
  - sp_in=FFFF reads FFFF then 0000; sp_out=0001.
  - sp_in=FFFE gives sp_out=0000.
- start while busy: ignored (decode guarantees no overlap; assertion fires in sim).
- mem_ack outside RD_LO/RD_HI: ignored.
- Reset mid-operation: immediate return to IDLE; no done; mem_rd deasserts asynchronously.
- Outputs ip_out/sp_out/taken/mcycles hold their FIN values until the next FIN.

Optional Feature:
- Macro Z80_RETN_IFF_EN.
- Defined: when is_retn and the return is taken, FIN asserts iff1_wr=1 with iff1_val=latched iff2.
- Undefined: iff1_wr tied 0, iff1_val tied 0; is_retn ignored; RETN/RETI behave as plain RET.

Decomposition:
- Shared package z80_pkg:
  - condition-code enum (CC_NZ..CC_M);
  - flag bit positions (FLAG_S=7, FLAG_Z=6, FLAG_PV=2, FLAG_C=0);
  - sequencer state enum;
  - cycle-type constants shared with the z80fi spec signals.
- One natural sub-module: z80_cond_eval, combinational (cc, flags) -> taken; reused by JP cc/CALL cc/JR cc.

Test Plan:
- RET, sp_in=1000, mem[1000]=34, mem[1001]=12, ack on first request cycle -> done 4 cycles after start, ip_out=1234, sp_out=1002, mcycles=2.
- RET Z with flags=00 (Z=0), sp_in=2000 -> no mem_rd ever, done after EXT, taken=0, ip_out=ip_in, sp_out=2000, mcycles=0.
- RET M with flags=80, sp_in=FFFF, mem[FFFF]=CD, mem[0000]=AB -> addresses FFFF then 0000, ip_out=ABCD, sp_out=0001.
- RET with 3 wait cycles before each ack -> mem_rd and mem_addr stable throughout, done exactly 1 cycle after second ack, ip_out correct.
- reset_n low during RD_HI -> mem_rd=0 and busy=0 immediately, no done; a following RET with sp_in=3000 completes normally.
- With Z80_RETN_IFF_EN: RETN, iff2=1 -> done with iff1_wr=1, iff1_val=1. Without the macro -> iff1_wr=0.
